// File: rtl/murmur3_4byte_hasher.sv
// -----------------------------------------------------------------------------
// murmur3_4byte_hasher
//
// Three-stage pipelined MurmurHash3_x86_32 core for a single 4-byte block.
// One packed k-mer word is hashed under a 32-bit seed each clock; the
// resulting signature appears after three register stages, with no
// backpressure. The k-mer word is used directly as the block word k.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valid and data regs)
//   in_valid   seed/kmer are valid this cycle
//   seed       hash seed (initial h)
//   kmer       packed k-mer, block word k
//   out_valid  signature is valid this cycle
//   signature  MurmurHash3_x86_32 result, held while out_valid is low
// -----------------------------------------------------------------------------
module murmur3_4byte_hasher #(
   parameter int HASHER_DATA_BITS = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [HASHER_DATA_BITS-1:0] seed,
   input  logic [HASHER_DATA_BITS-1:0] kmer,
   output logic                        out_valid,
   output logic [HASHER_DATA_BITS-1:0] signature
);

   // The mixing constants and rotate amounts are defined only for 32-bit words.
   if (HASHER_DATA_BITS != 32) begin : g_width_check
      $error("murmur3_4byte_hasher: HASHER_DATA_BITS must be 32");
   end

   localparam logic [31:0] C1      = 32'hcc9e2d51;
   localparam logic [31:0] C2      = 32'h1b873593;
   localparam logic [31:0] N_ADD   = 32'he6546b64;
   localparam logic [31:0] M1      = 32'h85ebca6b;
   localparam logic [31:0] M2      = 32'hc2b2ae35;
   localparam logic [31:0] LEN     = 32'd4;

   // Block scramble: k1 = rotl(k*C1, 15) * C2
   function automatic logic [31:0] mix_k1(input logic [31:0] k);
      logic [31:0] t;
      t = k * C1;
      t = {t[16:0], t[31:17]};
      return t * C2;
   endfunction

   // Block merge into h plus length finalisation: rotl(h^k1,13)*5+N, then ^len
   function automatic logic [31:0] mix_h(input logic [31:0] h_in,
                                         input logic [31:0] k1);
      logic [31:0] t;
      t = h_in ^ k1;
      t = {t[18:0], t[31:19]};
      t = (t * 32'd5) + N_ADD;
      return t ^ LEN;
   endfunction

   // Final avalanche
   function automatic logic [31:0] fmix32(input logic [31:0] h_in);
      logic [31:0] t;
      t = h_in ^ (h_in >> 16);
      t = t * M1;
      t = t ^ (t >> 13);
      t = t * M2;
      return t ^ (t >> 16);
   endfunction

   logic        vld_p0;
   logic [31:0] k1_p0;
   logic [31:0] seed_p0;
   logic        vld_p1;
   logic [31:0] h_p1;
   logic        vld_p2;
   logic [31:0] sig_p2;

   // Stage 0: block scramble, seed carried alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         k1_p0   <= '0;
         seed_p0 <= '0;
      end else begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            k1_p0   <= mix_k1(kmer);
            seed_p0 <= seed;
         end
      end
   end

   // Stage 1: merge with seed and fold in length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         h_p1   <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            h_p1 <= mix_h(seed_p0, k1_p0);
         end
      end
   end

   // Stage 2: fmix32, registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         sig_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sig_p2 <= fmix32(h_p1);
         end
      end
   end

   assign out_valid = vld_p2;
   assign signature = sig_p2;

endmodule

// File: tb/tb_murmur3_4byte_hasher.sv
module tb_murmur3_4byte_hasher;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] seed;
   logic [31:0] kmer;
   logic        out_valid;
   logic [31:0] signature;

   int checks = 0;
   int errors = 0;

   murmur3_4byte_hasher #(.HASHER_DATA_BITS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .seed      (seed),
      .kmer      (kmer),
      .out_valid (out_valid),
      .signature (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Software MurmurHash3_x86_32 of one 4-byte little-endian block.
   function automatic logic [31:0] ref_hash(input logic [31:0] s, input logic [31:0] k);
      logic [31:0] k1;
      logic [31:0] h;
      k1 = k * 32'hcc9e2d51;
      k1 = (k1 << 15) | (k1 >> 17);
      k1 = k1 * 32'h1b873593;
      h  = s ^ k1;
      h  = (h << 13) | (h >> 19);
      h  = h * 32'd5 + 32'he6546b64;
      h  = h ^ 32'd4;
      h  = h ^ (h >> 16);
      h  = h * 32'h85ebca6b;
      h  = h ^ (h >> 13);
      h  = h * 32'hc2b2ae35;
      h  = h ^ (h >> 16);
      return h;
   endfunction

   // Model: each sampled cycle pushes {valid, hash}; the output seen after
   // an edge belongs to the input sampled two edges earlier.
   logic [32:0] q[$];
   logic        exp_v;
   logic [31:0] exp_sig;
   logic [31:0] last_sig;

   task automatic drive(input logic r, input logic v, input logic [31:0] s, input logic [31:0] k);
      logic [32:0] e;
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      seed     = s;
      kmer     = k;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         q.delete();
         last_sig = 32'd0;
         exp_v    = 1'b0;
         exp_sig  = 32'd0;
      end else begin
         q.push_back({v, ref_hash(s, k)});
         exp_v   = 1'b0;
         exp_sig = last_sig;
         if (q.size() == 3) begin
            e = q.pop_front();
            if (e[32]) begin
               exp_v    = 1'b1;
               exp_sig  = e[31:0];
               last_sig = e[31:0];
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; seed = '0; kmer = '0;
      q.delete(); last_sig = '0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, i[0], $urandom, $urandom);
         checks++;
         if (out_valid !== 1'b0 || signature !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d out_valid=%b signature=%h required 0/00000000", i, out_valid, signature);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0 || signature !== 32'd0) begin
            errors++;
            $display("FAIL reset_release cyc=%0d out_valid=%b signature=%h required 0/00000000", i, out_valid, signature);
         end
      end
   endtask

   // Single shot: out_valid must rise exactly at the third edge with the known value.
   task automatic single_shot(input string name, input logic [31:0] s, input logic [31:0] k,
                              input logic [31:0] want);
      drive(1'b1, 1'b1, s, k);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) drive(1'b1, 1'b0, 32'd0, 32'd0);
         checks++;
         if (i < 2 && out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid edge=%0d out_valid=%b required 0", name, i + 1, out_valid);
         end
         if (i == 2 && (out_valid !== 1'b1 || signature !== want)) begin
            errors++;
            $display("FAIL %s out_valid=%b signature=%h required 1/%h", name, out_valid, signature, want);
         end
      end
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      checks++;
      if (out_valid !== 1'b0 || signature !== want) begin
         errors++;
         $display("FAIL %s_hold out_valid=%b signature=%h required 0/%h", name, out_valid, signature, want);
      end
   endtask

   task automatic test_known_vectors();
      single_shot("vec_test", 32'h00000000, 32'h74736574, 32'hba6bd213);
      single_shot("vec_zero", 32'h00000000, 32'h00000000, 32'h2362f9de);
   endtask

   task automatic test_seeded();
      single_shot("vec_aaaa", 32'h9747b28c, 32'h61616161, 32'h5a97808a);
      single_shot("vec_abcd", 32'h9747b28c, 32'h64636261, 32'hf0478627);
   endtask

   task automatic test_back_to_back();
      logic [31:0] s[4];
      logic [31:0] k[4];
      logic [31:0] w[4];
      s = '{32'h0, 32'h0, 32'h9747b28c, 32'h9747b28c};
      k = '{32'h74736574, 32'h0, 32'h61616161, 32'h64636261};
      w = '{32'hba6bd213, 32'h2362f9de, 32'h5a97808a, 32'hf0478627};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, 1'b1, s[i], k[i]);
         else       drive(1'b1, 1'b0, 32'd0, 32'd0);
         if (i >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || signature !== w[i-2]) begin
               errors++;
               $display("FAIL stream idx=%0d out_valid=%b signature=%h required 1/%h", i - 2, out_valid, signature, w[i-2]);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0 || signature !== w[3]) begin
            errors++;
            $display("FAIL stream_tail cyc=%0d out_valid=%b signature=%h required 0/%h", i, out_valid, signature, w[3]);
         end
      end
   endtask

   task automatic test_random();
      drive(1'b1, 1'b1, 32'hac718add, 32'hab1020c5);
      for (int n = 0; n < 1000; ) begin
         logic v;
         v = ($urandom_range(0, 3) != 0);
         if (n == 0) v = 1'b1;
         if (n == 1) drive(1'b1, 1'b1, 32'hffffffff, 32'hffffffff);
         else        drive(1'b1, v, $urandom, $urandom);
         if (v || n == 1) n++;
         checks++;
         if (out_valid !== exp_v || signature !== exp_sig) begin
            errors++;
            $display("FAIL random n=%0d out_valid=%b signature=%h required %b/%h", n, out_valid, signature, exp_v, exp_sig);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== exp_v || signature !== exp_sig) begin
            errors++;
            $display("FAIL random_drain cyc=%0d out_valid=%b signature=%h required %b/%h", i, out_valid, signature, exp_v, exp_sig);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, $urandom, $urandom);
      // Three hashes are in flight; drop reset between edges.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || signature !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset_async out_valid=%b signature=%h required 0/00000000", out_valid, signature);
      end
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, $urandom, $urandom);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0 || signature !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_flush cyc=%0d out_valid=%b signature=%h required 0/00000000", i, out_valid, signature);
         end
      end
      single_shot("post_reset", 32'h00000000, 32'h74736574, 32'hba6bd213);
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_seeded();
      test_back_to_back();
      test_random();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
